// File: rtl/sync_frame_deserializer.sv
// Serial front end for one receive wire: hunts for a syncword, then
// shifts in one fixed-length frame MSB-first and holds it as a parallel
// word with a level done flag until the receive FSM releases it.
module sync_frame_deserializer #(
  parameter int                   SYNC_BITS  = 8,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD  = 8'hB5,
  parameter int                   FRAME_BITS = 16,
  parameter int                   CNT_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  game_active,
  input  logic                  receive_start,
  input  logic                  serial_in,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  receive_done,
  output logic                  hunting,
  output logic [CNT_BITS-1:0]   frames_cnt
);

  // The bit counter serves both as the fill count during HUNT and as the
  // payload bit index during SHIFT, so it must reach the larger of the two.
  localparam int MAX_BITS = (SYNC_BITS > FRAME_BITS) ? SYNC_BITS : FRAME_BITS;
  localparam int CW       = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_reg;
  logic [SYNC_BITS-1:0]  sync_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt_reg;

  logic [SYNC_BITS-1:0]  sync_shifted;
  logic [FRAME_BITS-1:0] frame_shifted;
  logic                  sync_full;
  logic                  sync_match;
  logic                  last_bit;

  // Post-shift views: the match test and the frame capture both look at
  // the value that includes the bit being sampled on this edge.
  assign sync_shifted  = {sync_reg[SYNC_BITS-2:0], serial_in};
  assign frame_shifted = {shift_reg[FRAME_BITS-2:0], serial_in};
  // A match is only trusted once SYNC_BITS fresh samples have been taken
  // since arming; otherwise the cleared register's zeros could complete
  // a syncword that has leading zeros.
  assign sync_full     = (bit_cnt_reg >= CW'(SYNC_BITS - 1));
  assign sync_match    = sync_full && (sync_shifted == SYNC_WORD);
  assign last_bit      = (bit_cnt_reg == CW'(FRAME_BITS - 1));

  // Single state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg    <= IDLE;
      sync_reg     <= '0;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      data_out     <= '0;
      receive_done <= 1'b0;
      hunting      <= 1'b0;
      frames_cnt   <= '0;
    end else if (!game_active) begin
      // Disable wins over every state and wipes the visible results.
      state_reg    <= IDLE;
      sync_reg     <= '0;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      data_out     <= '0;
      receive_done <= 1'b0;
      hunting      <= 1'b0;
      frames_cnt   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (receive_start) begin
            state_reg   <= HUNT;
            hunting     <= 1'b1;
            sync_reg    <= '0;
            bit_cnt_reg <= '0;
          end
        end

        HUNT: begin
          if (!receive_start) begin
            state_reg <= IDLE;
            hunting   <= 1'b0;
          end else begin
            sync_reg <= sync_shifted;
            if (sync_match) begin
              state_reg   <= SHIFT;
              hunting     <= 1'b0;
              bit_cnt_reg <= '0;
            end else if (!sync_full) begin
              bit_cnt_reg <= bit_cnt_reg + CW'(1);
            end
          end
        end

        SHIFT: begin
          if (!receive_start) begin
            // Abort: the partial frame is simply dropped.
            state_reg <= IDLE;
          end else begin
            shift_reg   <= frame_shifted;
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
            if (last_bit) begin
              data_out     <= frame_shifted;
              receive_done <= 1'b1;
              frames_cnt   <= frames_cnt + CNT_BITS'(1);
              state_reg    <= DONE;
            end
          end
        end

        DONE: begin
          // Hold the frame until the receive FSM lets go of receive_start.
          if (!receive_start) begin
            receive_done <= 1'b0;
            state_reg    <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          hunting   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_frame_deserializer.sv
// Self-checking bench for sync_frame_deserializer: streams of bits are
// built per scenario, a bit-stream reference model predicts where the
// syncword matches and which frame completes, and the DUT is compared
// cycle by cycle against that prediction.
module tb_sync_frame_deserializer;

  localparam int SB = 8;
  localparam int FB = 16;
  localparam int CB = 4;
  localparam logic [7:0] SYNC = 8'hB5;

  logic          clk;
  logic          rst_l;
  logic          game_active;
  logic          receive_start;
  logic          serial_in;
  logic [FB-1:0] data_out;
  logic          receive_done;
  logic          hunting;
  logic [CB-1:0] frames_cnt;

  int checks = 0;
  int errors = 0;

  logic [FB-1:0] exp_data = '0;
  int            exp_cnt  = 0;
  bit            stim[$];

  sync_frame_deserializer #(
    .SYNC_BITS (SB),
    .SYNC_WORD (SYNC),
    .FRAME_BITS(FB),
    .CNT_BITS  (CB)
  ) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .game_active  (game_active),
    .receive_start(receive_start),
    .serial_in    (serial_in),
    .data_out     (data_out),
    .receive_done (receive_done),
    .hunting      (hunting),
    .frames_cnt   (frames_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // Reference model: scan the bit stream sampled since arming. The first
  // position at which the most recent SB bits (with at least SB bits seen)
  // equal the syncword is the match; the next FB bits are the frame.
  function automatic void model(output bit matched, output bit found,
                                output logic [FB-1:0] frame,
                                output int match_idx, output int done_idx);
    logic [SB-1:0] window;
    window    = '0;
    matched   = 1'b0;
    found     = 1'b0;
    frame     = '0;
    match_idx = -1;
    done_idx  = -1;
    for (int i = 0; i < stim.size(); i++) begin
      window = {window[SB-2:0], stim[i]};
      if (i >= SB - 1 && window == SYNC) begin
        matched   = 1'b1;
        match_idx = i;
        if (i + FB < stim.size()) begin
          found    = 1'b1;
          done_idx = i + FB;
          for (int j = 1; j <= FB; j++) frame = {frame[FB-2:0], stim[i + j]};
        end
        break;
      end
    end
  endfunction

  task automatic push_word(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) stim.push_back(w[i]);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) stim.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic step(input bit b);
    @(negedge clk);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input string name);
    @(negedge clk);
    receive_start = 1'b1;
    serial_in     = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (hunting !== 1'b1 || receive_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_arm: hunting=%b done=%b, required hunting=1 done=0", name, hunting, receive_done);
    end
  endtask

  task automatic disarm(input string name);
    @(negedge clk);
    receive_start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (receive_done !== 1'b0 || hunting !== 1'b0 || data_out !== exp_data) begin
      errors++;
      $display("FAIL %s_disarm: done=%b hunting=%b data=%h, required done=0 hunting=0 data=%h",
               name, receive_done, hunting, data_out, exp_data);
    end
  endtask

  // Drive the queued stream, check done/hunting every cycle against the
  // model, then check the held word, counter and number of done rises.
  task automatic run_stream(input string name);
    bit            matched, found, exp_done, exp_hunt, prev_done;
    logic [FB-1:0] frame;
    int            match_idx, done_idx, rises, bad;
    model(matched, found, frame, match_idx, done_idx);
    rises     = 0;
    bad       = 0;
    prev_done = receive_done;
    for (int k = 0; k < stim.size(); k++) begin
      step(stim[k]);
      exp_done = found && (k >= done_idx);
      exp_hunt = !matched || (k < match_idx);
      if (receive_done && !prev_done) rises++;
      prev_done = receive_done;
      checks++;
      if (receive_done !== exp_done || hunting !== exp_hunt) begin
        errors++;
        bad++;
        if (bad <= 4)
          $display("FAIL %s_cycle%0d: done=%b hunting=%b, required done=%b hunting=%b",
                   name, k, receive_done, hunting, exp_done, exp_hunt);
      end
    end
    if (found) begin
      exp_cnt  = (exp_cnt + 1) % (1 << CB);
      exp_data = frame;
    end
    checks++;
    if (rises != (found ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_rises: got %0d done rises, required %0d", name, rises, found ? 1 : 0);
    end
    checks++;
    if (data_out !== exp_data || frames_cnt !== CB'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_result: data=%h cnt=%0d, required data=%h cnt=%0d",
               name, data_out, frames_cnt, exp_data, exp_cnt);
    end
    $display("stream %s: %0d bits, match@%0d done@%0d data=%h cnt=%0d",
             name, stim.size(), match_idx, done_idx, data_out, frames_cnt);
    stim.delete();
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (data_out !== '0 || receive_done !== 1'b0 || hunting !== 1'b0 || frames_cnt !== '0) begin
      errors++;
      $display("FAIL %s: data=%h done=%b hunting=%b cnt=%0d, required all 0",
               name, data_out, receive_done, hunting, frames_cnt);
    end
  endtask

  task automatic test_reset();
    rst_l         = 1'b0;
    game_active   = 1'b1;
    receive_start = 1'b0;
    serial_in     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_l = 1'b1;
    step(1'b1);
    check_zero("reset_idle");
    $display("test_reset done");
  endtask

  task automatic test_basic();
    arm("basic");
    push_word(16'h0000, 3);
    push_word(16'h00B5, 8);
    push_word(16'hC3A5, 16);
    push_rand(3);
    run_stream("basic");
    checks++;
    if (data_out !== 16'hC3A5 || frames_cnt !== 4'd1) begin
      errors++;
      $display("FAIL basic_value: data=%h cnt=%0d, required c3a5 cnt=1", data_out, frames_cnt);
    end
    disarm("basic");
  endtask

  task automatic test_false_sync();
    arm("false_sync");
    push_word(16'h00B4, 8);
    push_word(16'h005B, 8);
    push_word(16'h00B5, 8);
    push_word(16'h0F0F, 16);
    run_stream("false_sync");
    disarm("false_sync");
  endtask

  task automatic test_payload_sync();
    arm("payload_sync");
    push_word(16'h00B5, 8);
    push_word(16'hB5B5, 16);
    push_word(16'hB5B5, 16);
    push_rand(8);
    run_stream("payload_sync");
    disarm("payload_sync");
  endtask

  task automatic test_back_to_back();
    int cnt_before;
    arm("second");
    push_word(16'h00B5, 8);
    push_word(16'h1234, 16);
    run_stream("second");
    disarm("second");
    cnt_before = exp_cnt;
    for (int f = 0; f < 16; f++) begin
      arm("b2b");
      push_word(16'h00B5, 8);
      push_word(16'($urandom), 16);
      run_stream("b2b");
      disarm("b2b");
    end
    checks++;
    if (frames_cnt !== CB'(cnt_before)) begin
      errors++;
      $display("FAIL b2b_wrap: cnt=%0d, required %0d", frames_cnt, cnt_before);
    end
  endtask

  task automatic test_abort();
    arm("abort");
    push_word(16'h00B5, 8);
    push_rand(7);
    run_stream("abort");
    @(negedge clk);
    receive_start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (receive_done !== 1'b0 || hunting !== 1'b0 || data_out !== exp_data || frames_cnt !== CB'(exp_cnt)) begin
      errors++;
      $display("FAIL abort_hold: done=%b hunting=%b data=%h cnt=%0d, required done=0 hunting=0 data=%h cnt=%0d",
               receive_done, hunting, data_out, frames_cnt, exp_data, exp_cnt);
    end
    // Remaining payload bits with receive_start low must be ignored.
    for (int i = 0; i < 9; i++) step(1'($urandom_range(0, 1)));
    check_idle_hold("abort_idle");
    arm("after_abort");
    push_word(16'h00B5, 8);
    push_word(16'($urandom), 16);
    run_stream("after_abort");
    disarm("after_abort");
  endtask

  task automatic check_idle_hold(input string name);
    checks++;
    if (receive_done !== 1'b0 || hunting !== 1'b0 || data_out !== exp_data || frames_cnt !== CB'(exp_cnt)) begin
      errors++;
      $display("FAIL %s: done=%b hunting=%b data=%h cnt=%0d, required done=0 hunting=0 data=%h cnt=%0d",
               name, receive_done, hunting, data_out, frames_cnt, exp_data, exp_cnt);
    end
  endtask

  task automatic test_disable_reset();
    arm("disable");
    push_word(16'h00B5, 8);
    push_rand(5);
    run_stream("disable");
    @(negedge clk);
    game_active = 1'b0;
    @(posedge clk);
    #1;
    exp_cnt  = 0;
    exp_data = '0;
    check_zero("disable_clear");
    @(negedge clk);
    game_active   = 1'b1;
    receive_start = 1'b0;
    step(1'b0);

    // Complete one frame so reset has nonzero outputs to clear.
    arm("pre_reset");
    push_word(16'h00B5, 8);
    push_word(16'h5AA5, 16);
    run_stream("pre_reset");
    disarm("pre_reset");
    arm("reset_mid");
    push_word(16'h00B5, 8);
    push_rand(3);
    run_stream("reset_mid");
    @(negedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    exp_cnt  = 0;
    exp_data = '0;
    check_zero("async_reset");
    receive_start = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    step(1'b0);

    arm("fresh");
    push_word(16'h00B5, 8);
    push_word(16'hFFFF, 16);
    run_stream("fresh");
    checks++;
    if (data_out !== 16'hFFFF || frames_cnt !== 4'd1) begin
      errors++;
      $display("FAIL fresh_value: data=%h cnt=%0d, required ffff cnt=1", data_out, frames_cnt);
    end
    disarm("fresh");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      arm("random");
      push_rand($urandom_range(0, 20));
      push_word(16'h00B5, 8);
      push_word(16'($urandom), 16);
      push_rand($urandom_range(0, 4));
      run_stream("random");
      disarm("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_sync();
    test_payload_sync();
    test_back_to_back();
    test_abort();
    test_disable_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
